// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared constants and types for the multi-cycle divider.
//   State encodings, ready/start levels, step count, result payload type,
//   and a helper that takes the magnitude of a signed operand.
package div_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WORK_W = 2 * DATA_W + 1;
  localparam int unsigned CNT_W  = 6;

  // FSM state encodings
  localparam logic [1:0] DIV_FREE   = 2'b00;
  localparam logic [1:0] DIV_BYZERO = 2'b01;
  localparam logic [1:0] DIV_ON     = 2'b10;
  localparam logic [1:0] DIV_END    = 2'b11;

  // Handshake levels
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // One quotient bit per step
  localparam logic [CNT_W-1:0] DIV_STEPS = 6'd32;

  // {HI = remainder, LO = quotient}
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } div_result_t;

  // Two's-complement magnitude when the operand is treated as signed and negative.
  function automatic logic [DATA_W-1:0] abs_if_signed(input logic          is_signed,
                                                      input logic [DATA_W-1:0] v);
    return (is_signed && v[DATA_W-1]) ? DATA_W'(~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration (combinational).
//   work_i    : {partial remainder[32:0], remaining dividend / quotient bits[31:0]}
//   divisor_i : divisor magnitude
//   work_o    : working register after shifting in one quotient bit at bit 0
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [WORK_W-1:0] work_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [WORK_W-1:0] work_o
);

  logic              ge_c;
  logic [DATA_W:0]   sub_c;

  // Window = remainder shifted left with the next dividend bit appended.
  // The remainder is always below the divisor, so a 33-bit wrapped
  // difference is exact whenever the subtraction is taken.
  always_comb begin
    ge_c   = work_i[WORK_W-1:DATA_W-1] >= (DATA_W+2)'(divisor_i);
    sub_c  = work_i[WORK_W-2:DATA_W-1] - (DATA_W+1)'(divisor_i);
    work_o = ge_c ? {sub_c, work_i[DATA_W-2:0], 1'b1}
                  : {work_i[WORK_W-2:0], 1'b0};
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: 32-bit signed/unsigned restoring divider controller.
//   clk, rst (async, active-low)
//   signed_div_i, opdata1_i (dividend), opdata2_i (divisor)
//   start_i (held until ready_o), annul_i (flush of in-flight divide)
//   result_o {HI=remainder, LO=quotient}, ready_o (registered)
//   stallreq_o (combinational stall request)
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [WORK_W-1:0] work_q,    work_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic              sign1_q,   sign1_d;
  logic              sign2_q,   sign2_d;
  logic              signed_q,  signed_d;
  div_result_t       result_q,  result_d;
  logic              ready_q,   ready_d;

  logic [WORK_W-1:0] step_work;
  logic [DATA_W-1:0] quot_fix, rem_fix;

  div_step u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_work)
  );

  // Sign fix-up applied to the final step's output as the FSM enters END
  always_comb begin
    quot_fix = step_work[DATA_W-1:0];
    rem_fix  = step_work[2*DATA_W-1:DATA_W];
    if (signed_q && (sign1_q ^ sign2_q)) quot_fix = DATA_W'(~quot_fix + DATA_W'(1));
    if (signed_q && sign1_q)             rem_fix  = DATA_W'(~rem_fix + DATA_W'(1));
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    signed_d  = signed_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            work_d    = {(DATA_W+1)'(0), abs_if_signed(signed_div_i, opdata1_i)};
            divisor_d = abs_if_signed(signed_div_i, opdata2_i);
            sign1_d   = opdata1_i[DATA_W-1];
            sign2_d   = opdata2_i[DATA_W-1];
            signed_d  = signed_div_i;
            cnt_d     = '0;
            state_d   = DIV_ON;
          end
        end
      end
      DIV_BYZERO: begin
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
        state_d  = DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          state_d  = DIV_FREE;
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q + CNT_W'(1);
          // Last step lands directly in END so ready_o follows edge 33
          if (cnt_q == DIV_STEPS - CNT_W'(1)) begin
            result_d = '{hi: rem_fix, lo: quot_fix};
            ready_d  = DIV_RESULT_READY;
            state_d  = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          state_d  = DIV_FREE;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        state_d  = DIV_FREE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed self-checking bench for div_ctrl.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int compares = 0;
  int errs     = 0;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request with start held; check latency, stall, hold in END and release.
  task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int n;
    signed_div = s; op1 = a; op2 = b; annul = 1'b0; start = 1'b1;
    n = 0;
    #1;
    while (!ready && n < 60) begin
      check({tag, " stall"}, 64'(stallreq), 64'(1));
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " stall_at_ready"}, 64'(stallreq), 64'(0));
    tick();
    check({tag, " hold_ready"}, 64'(ready), 64'(1));
    check({tag, " hold_result"}, result, exp_res);
    start = 1'b0;
    tick();
    check({tag, " drop_ready"}, 64'(ready), 64'(0));
    check({tag, " drop_result"}, result, 64'(0));
  endtask

  initial begin
    int seen;
    rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    #1 rst = 1'b0;
    tick();
    tick();
    check("reset ready", 64'(ready), 64'(0));
    check("reset result", result, 64'(0));
    check("reset state", 64'(dut.state_q), 64'(DIV_FREE));
    check("reset cnt", 64'(dut.cnt_q), 64'(0));
    rst = 1'b1;
    tick();
    check("idle ready", 64'(ready), 64'(0));

    do_div("u100/7", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 33);
    do_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    do_div("s7/-2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    do_div("uFFFFFFF9/2", 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, {32'h0000_0001, 32'h7FFF_FFFC}, 33);
    do_div("uFFFFFFFF/80000001", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, {32'h7FFF_FFFE, 32'h0000_0001}, 33);
    do_div("u12345/0", 1'b0, 32'd12345, 32'd0, 64'(0), 2);
    do_div("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 64'(0), 2);

    // Annul at counter 10
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (11) tick();
    check("annul cnt", 64'(dut.cnt_q), 64'(10));
    annul = 1'b1;
    #1;
    check("annul stall", 64'(stallreq), 64'(0));
    tick();
    check("annul state", 64'(dut.state_q), 64'(DIV_FREE));
    check("annul ready", 64'(ready), 64'(0));
    annul = 1'b0; start = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (ready) seen++;
    end
    check("annul no_ready", 64'(seen), 64'(0));
    do_div("u9/3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

    // Asynchronous reset at counter 20
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (21) tick();
    check("rst cnt", 64'(dut.cnt_q), 64'(20));
    start = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst ready", 64'(ready), 64'(0));
    check("rst result", result, 64'(0));
    check("rst stall", 64'(stallreq), 64'(0));
    check("rst state", 64'(dut.state_q), 64'(DIV_FREE));
    check("rst cnt0", 64'(dut.cnt_q), 64'(0));
    tick();
    #1 rst = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (ready) seen++;
    end
    check("rst no_ready", 64'(seen), 64'(0));
    check("rst idle state", 64'(dut.state_q), 64'(DIV_FREE));

    do_div("s80000000/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
    $finish;
  end

endmodule
